// File: rtl/call_announcer.sv
// call_announcer: queues service-counter call events in a 4-entry FIFO and
// presents them one at a time on a multiplexed 4-digit seven-segment display.
// Each call is held for HOLD_CYCLES with the hall flash asserted. When no call
// is pending, the last call stays on the display. Until the first call is
// shown, all digits display a dash.
module call_announcer #(
  parameter int HOLD_CYCLES = 16,
  parameter int SCAN_DIV    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       call_valid,
  input  logic [2:0] call_counter,
  input  logic [5:0] call_number,
  output logic       call_ready,
  output logic       flash,
  output logic       drop_err,
  output logic [2:0] pending,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2
  } state_t;

  // FIFO entry: {counter id, ticket number}
  typedef struct packed {
    logic [2:0] counter;
    logic [5:0] number;
  } call_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  call_t      mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       push;
  logic       pop;
  call_t      head;
  logic       head_valid;

  state_t        state;
  state_t        state_next;
  logic [HW-1:0] hold_cnt;
  logic          hold_done;

  assign call_ready = (count != 3'd4);
  assign pending    = count;
  assign push       = call_valid && call_ready;
  assign pop        = (state == LOAD);
  assign head       = mem[rd_ptr];
  assign head_valid = (head.counter <= 3'd4);
  assign hold_done  = (hold_cnt == HW'(HOLD_CYCLES - 1));

  // FIFO storage write
  // NOTE: storage is deliberately not reset; count and pointers alone decide
  // which entries are live, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{counter: call_counter, number: call_number};
  end

  // FIFO pointers and occupancy
  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop)      count <= count + 3'd1;
      else if (!push && pop) count <= count - 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Presentation FSM
  // ---------------------------------------------------------------------------

  // Next-state logic
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (count != 3'd0) state_next = LOAD;
      LOAD: state_next = head_valid ? SHOW : IDLE;
      SHOW: if (hold_done) state_next = (count != 3'd0) ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic [2:0] disp_counter;
  logic [5:0] disp_number;
  logic       shown;

  // State register, hold timer, flash/drop outputs and display registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      flash        <= 1'b0;
      drop_err     <= 1'b0;
      disp_counter <= 3'd0;
      disp_number  <= 6'd0;
      shown        <= 1'b0;
    end else begin
      state    <= state_next;
      flash    <= (state_next == SHOW);
      drop_err <= (state == LOAD) && !head_valid;
      if (state == LOAD) hold_cnt <= '0;
      else if (state == SHOW) hold_cnt <= hold_cnt + HW'(1);
      if (state == LOAD && head_valid) begin
        disp_counter <= head.counter;
        disp_number  <= head.number;
        shown        <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display content
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    unique case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_DASH;
    endcase
  endfunction

  function automatic logic [6:0] letter_seg(input logic [2:0] c);
    unique case (c)
      3'd0:    return 7'b0001000; // A
      3'd1:    return 7'b0000011; // b
      3'd2:    return 7'b1000110; // C
      3'd3:    return 7'b0100001; // d
      3'd4:    return 7'b0000110; // E
      default: return SEG_DASH;
    endcase
  endfunction

  logic [2:0] tens;
  logic [3:0] units;

  // Decimal split of the latched number (0..63) by range comparison
  always_comb begin
    tens = 3'd0;
    if      (disp_number >= 6'd60) tens = 3'd6;
    else if (disp_number >= 6'd50) tens = 3'd5;
    else if (disp_number >= 6'd40) tens = 3'd4;
    else if (disp_number >= 6'd30) tens = 3'd3;
    else if (disp_number >= 6'd20) tens = 3'd2;
    else if (disp_number >= 6'd10) tens = 3'd1;
    units = 4'(disp_number - 6'(tens) * 6'd10);
  end

  // ---------------------------------------------------------------------------
  // Digit scan
  // ---------------------------------------------------------------------------
  logic [DW-1:0] div_cnt;
  logic          div_wrap;
  logic [1:0]    dig;
  logic [1:0]    dig_next;
  logic [6:0]    seg_next;

  assign div_wrap = (div_cnt == DW'(SCAN_DIV - 1));
  assign dig_next = div_wrap ? dig + 2'd1 : dig;

  // Segment pattern for the digit being selected on this edge
  always_comb begin
    seg_next = SEG_DASH;
    if (shown) begin
      unique case (dig_next)
        2'd3: seg_next = letter_seg(disp_counter);
        2'd2: seg_next = SEG_BLANK;
        2'd1: seg_next = (tens == 3'd0) ? SEG_BLANK : digit_seg({1'b0, tens});
        2'd0: seg_next = digit_seg(units);
        default: seg_next = SEG_DASH;
      endcase
    end
  end

  // Scan divider, digit index and registered an/seg drive; an/seg follow the
  // index it takes on this edge so every digit is lit for exactly SCAN_DIV cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      dig     <= 2'd0;
      an      <= 4'b1110;
      seg     <= SEG_DASH;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + DW'(1);
      dig     <= dig_next;
      an      <= ~(4'b0001 << dig_next);
      seg     <= seg_next;
    end
  end

endmodule

// File: tb/tb_call_announcer.sv
// Testbench for call_announcer: directed calls with hand-computed segment
// patterns. Stimulus queues expected windows/drops; a monitor pops and checks
// them whenever the DUT raises flash or pulses drop_err.
module tb_call_announcer;

  localparam int HOLD = 16;
  localparam int SD   = 4;

  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] L_A = 7'b0001000, L_B = 7'b0000011, L_C = 7'b1000110;
  localparam logic [6:0] L_D = 7'b0100001, L_E = 7'b0000110;
  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000, D4 = 7'b0011001, D5 = 7'b0010010;
  localparam logic [6:0] D6 = 7'b0000010, D7 = 7'b1111000;

  logic       clk = 1'b0;
  logic       rst;
  logic       call_valid;
  logic [2:0] call_counter;
  logic [5:0] call_number;
  logic       call_ready;
  logic       flash;
  logic       drop_err;
  logic [2:0] pending;
  logic [3:0] an;
  logic [6:0] seg;

  always #5 clk = ~clk;

  call_announcer #(.HOLD_CYCLES(HOLD), .SCAN_DIV(SD)) dut (
    .clk          (clk),
    .rst          (rst),
    .call_valid   (call_valid),
    .call_counter (call_counter),
    .call_number  (call_number),
    .call_ready   (call_ready),
    .flash        (flash),
    .drop_err     (drop_err),
    .pending      (pending),
    .an           (an),
    .seg          (seg)
  );

  typedef struct {
    bit         is_drop;
    logic [6:0] d3;
    logic [6:0] d1;
    logic [6:0] d0;
    int         gap;   // required flash-low cycles before this window, 0 = any
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b1;
  bit   in_win = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic expect_show(input logic [6:0] d3, input logic [6:0] d1,
                             input logic [6:0] d0, input int gap);
    exp_t e;
    e.is_drop = 1'b0; e.d3 = d3; e.d1 = d1; e.d0 = d0; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic expect_drop();
    exp_t e;
    e.is_drop = 1'b1; e.d3 = '0; e.d1 = '0; e.d0 = '0; e.gap = 0;
    exp_q.push_back(e);
  endtask

  // Present one call and hold it until accepted; returns 1 time unit after
  // the accepting edge.
  task automatic push(input logic [2:0] c, input logic [5:0] n);
    bit ok;
    ok = 1'b0;
    call_valid = 1'b1; call_counter = c; call_number = n;
    for (int i = 0; i < 400 && !ok; i++) begin
      ok = call_ready;
      @(posedge clk);
      #1;
    end
    call_valid = 1'b0;
    if (!ok) check("push_timeout", 0, 1);
  endtask

  task automatic wait_drain(input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !in_win && !flash && (pending == 3'd0);
    end
    check("drain_timeout", done, 1);
  endtask

  // Sample a couple of full scan periods and compare the steady display
  task automatic check_display(input string name, input logic [6:0] d3,
                               input logic [6:0] d1, input logic [6:0] d0);
    logic [6:0] cap [4];
    for (int i = 0; i < 4; i++) cap[i] = 7'h00;
    for (int i = 0; i < 8 * SD; i++) begin
      @(negedge clk);
      if (an_idx(an) >= 0) cap[an_idx(an)] = seg;
    end
    check({name, "_d3"}, cap[3], d3);
    check({name, "_d2"}, cap[2], BLANK);
    check({name, "_d1"}, cap[1], d1);
    check({name, "_d0"}, cap[0], d0);
  endtask

  // Monitor: pops the scoreboard on each drop pulse and each flash window
  initial begin
    logic       pf;
    int         w, low, idx;
    bit         gap_known;
    exp_t       cur;
    logic [6:0] cap [4];
    pf = 1'b0; w = 0; low = 0; gap_known = 1'b0;
    cur.is_drop = 1'b0; cur.d3 = '0; cur.d1 = '0; cur.d0 = '0; cur.gap = 0;
    for (int i = 0; i < 4; i++) cap[i] = 7'h00;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 || !mon_en) begin
        pf = 1'b0; w = 0; low = 0; gap_known = 1'b0; in_win = 1'b0;
        continue;
      end
      if (drop_err) begin
        if (exp_q.size() == 0) check("drop_unexpected", 1, 0);
        else begin
          cur = exp_q.pop_front();
          check("drop_kind", cur.is_drop, 1);
        end
      end
      if (flash && !pf) begin
        if (exp_q.size() == 0) begin
          check("show_unexpected", 1, 0);
          cur.is_drop = 1'b0; cur.d3 = '0; cur.d1 = '0; cur.d0 = '0; cur.gap = 0;
        end else begin
          cur = exp_q.pop_front();
          check("show_kind", cur.is_drop, 0);
          if (cur.gap > 0 && gap_known) check("flash_gap", low, cur.gap);
        end
        in_win = 1'b1; w = 0;
        for (int i = 0; i < 4; i++) cap[i] = 7'h00;
      end
      if (flash) begin
        w++;
        idx = an_idx(an);
        if (idx >= 0) cap[idx] = seg;
      end else if (pf) begin
        check("flash_width", w, HOLD);
        check("win_d3", cap[3], cur.d3);
        check("win_d2", cap[2], BLANK);
        check("win_d1", cap[1], cur.d1);
        check("win_d0", cap[0], cur.d0);
        in_win = 1'b0; gap_known = 1'b1; low = 1;
      end else begin
        low++;
      end
      pf = flash;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         k, bad;
    logic [3:0] ea;
    rst = 1'b0; call_valid = 1'b0; call_counter = 3'd0; call_number = 6'd0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready",   call_ready, 1);
    check("rst_flash",   flash, 0);
    check("rst_drop",    drop_err, 0);
    check("rst_pending", pending, 0);
    check("rst_an",      an, 4'b1110);
    check("rst_seg",     seg, DASH);
    rst = 1'b1;

    // Idle scan: each digit SD cycles, dashes throughout
    k = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); k++;
      @(negedge clk);
      ea = ~(4'b0001 << ((k / SD) % 4));
      check("idle_an", an, ea);
      if (seg !== DASH || flash !== 1'b0 || call_ready !== 1'b1) bad++;
    end
    check("idle_seg_flash_ready", bad, 0);

    // Single call C17 with explicit latency
    expect_show(L_C, D1, D7, 0);
    push(3'd2, 6'd17);
    @(negedge clk); check("lat_n",  flash, 0);
    @(negedge clk); check("lat_n1", flash, 0);
    @(negedge clk); check("lat_n2", flash, 1);
    check("lat_n2_pending", pending, 0);
    wait_drain(200);
    check_display("hold_c17", L_C, D1, D7);

    // Five consecutive calls, FIFO fills
    expect_show(L_A, BLANK, D1, 0);
    expect_show(L_B, BLANK, D2, 1);
    expect_show(L_C, BLANK, D3, 1);
    expect_show(L_D, BLANK, D4, 1);
    expect_show(L_E, BLANK, D5, 1);
    push(3'd0, 6'd1);
    push(3'd1, 6'd2);
    push(3'd2, 6'd3);
    push(3'd3, 6'd4);
    push(3'd4, 6'd5);
    check("full_pending", pending, 4);
    check("full_ready",   call_ready, 0);
    k = 0;
    while (!call_ready && k < 200) begin @(negedge clk); k++; end
    check("ready_rise", call_ready, 1);
    check("ready_rise_pending", pending, 3);
    wait_drain(400);

    // Invalid id is dropped, then A0
    expect_drop();
    expect_show(L_A, BLANK, D0, 0);
    push(3'd6, 6'd42);
    push(3'd0, 6'd0);
    wait_drain(200);

    // Reset mid-SHOW with two calls queued
    mon_en = 1'b0;
    push(3'd1, 6'd10);
    push(3'd2, 6'd20);
    push(3'd3, 6'd30);
    repeat (5) @(negedge clk);
    check("mid_show_flash",   flash, 1);
    check("mid_show_pending", pending, 2);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_pending", pending, 0);
    check("mid_rst_flash",   flash, 0);
    check("mid_rst_seg",     seg, DASH);
    check("mid_rst_an",      an, 4'b1110);
    check("mid_rst_ready",   call_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (flash !== 1'b0 || seg !== DASH || pending !== 3'd0 || drop_err !== 1'b0) bad++;
    end
    check("post_rst_quiet", bad, 0);

    // E63
    expect_show(L_E, D6, D3, 0);
    push(3'd4, 6'd63);
    wait_drain(200);
    check_display("hold_e63", L_E, D6, D3);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
